// File: rtl/ones_run_pkg.sv
// Shared definitions for the ones-run stimulus transmitter: FSM encoding,
// default request width and the counter-width helper.
package ones_run_pkg;

    localparam int DEF_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        TERM = 2'b10,
        GAP  = 2'b11
    } state_t;

    // The counter serves both the run phase and the idle gap, so it must fit either.
    function automatic int cnt_width(input int len_w, input int gap_cycles);
        int gap_w;
        gap_w = $clog2(gap_cycles + 1);
        return (gap_w > len_w) ? gap_w : len_w;
    endfunction

endpackage

// File: rtl/ones_run_counter.sv
// Loadable down-counter shared by the RUN and GAP phases; holds at zero.
module ones_run_counter #(
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          is_zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/ones_run_tx.sv
// Emits req_len ones, one terminating zero and GAP_CYCLES idle zeros per request,
// flagging the cycle in which a downstream zero detector should fire.
module ones_run_tx
    import ones_run_pkg::*;
#(
    parameter int LEN_W      = DEF_LEN_W,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    output logic             x_out,
    output logic             busy,
    output logic             expect_y,
    output logic             done
);

    localparam int            CW       = cnt_width(LEN_W, GAP_CYCLES);
    localparam logic          GAP_EN   = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] GAP_LOAD = GAP_EN ? CW'(GAP_CYCLES - 1) : '0;

    state_t        state;
    logic          len_nz;
    logic          accept;
    logic          req_nz;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt_val;
    logic          cnt_zero;

    assign accept = req_valid && (state == IDLE);
    assign req_nz = (req_len != '0);

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                cnt_load = accept && req_nz;
                cnt_val  = CW'(req_len) - CW'(1);
            end
            RUN:  cnt_dec = 1'b1;
            TERM: begin
                cnt_load = GAP_EN;
                cnt_val  = GAP_LOAD;
            end
            GAP:  cnt_dec = 1'b1;
            default: ;
        endcase
    end

    ones_run_counter #(.CW(CW)) u_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .is_zero  (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            len_nz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    len_nz <= req_nz;
                    state  <= req_nz ? RUN : TERM;
                end
                RUN:  if (cnt_zero) state <= TERM;
                TERM: state <= GAP_EN ? GAP : IDLE;
                GAP:  if (cnt_zero) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, never on the request inputs.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign x_out     = (state == RUN);
    assign expect_y  = (state == TERM) && len_nz;
    assign done      = ((state == TERM) && !GAP_EN) || ((state == GAP) && cnt_zero);

endmodule

// File: doc/ones_run_tx.md
Name: ones_run_tx

Overview:
Serial stimulus transmitter that drives the single-bit line consumed by the team's Mealy zero-sequence detector. It accepts a run-length request over a valid/ready handshake. It then emits exactly that many 1s, one terminating 0, and a configurable idle gap of 0s. It also flags the exact cycle in which a downstream zero detector must assert its output, which makes it usable both in system datapaths and as a verification driver.

Parameters:
LEN_W, 4, width of run-length request; maximum run = 2^LEN_W - 1 ones
GAP_CYCLES, 1, number of idle 0 cycles after the terminator (0 allowed)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_len  input  LEN_W  number of 1s to emit
req_ready  output  1  block can accept a request (high only in IDLE)
x_out  output  1  serial line to detector, idles at 0
busy  output  1  high in any state other than IDLE
expect_y  output  1  high in the terminator cycle of a run with len >= 1
done  output  1  one-cycle pulse in the final cycle of a transaction

Behaviour:
- Reset: sampled on rising clock edge while reset==0. Forces state=IDLE, counter=0, x_out=0, busy=0, expect_y=0, done=0, req_ready=1. Reset mid-run aborts immediately; no terminator is emitted.
- All outputs are Moore, decoded from registered state and counter; no combinational path from req_* to any output.
- States (2-bit): IDLE, RUN, TERM, GAP.
- IDLE: x_out=0, req_ready=1. On req_valid&&req_ready at edge k, latch req_len.
  - len>=1 -> RUN, counter=len-1.
  - len==0 -> TERM directly.
- RUN: x_out=1, req_ready=0. Counter decrements each cycle; when counter==0 -> TERM. The line is high for exactly len cycles (cycles k+1..k+len).
- TERM: x_out=0 for one cycle (cycle k+len+1). expect_y=1 only if latched len>=1.
  - GAP_CYCLES>0 -> GAP, counter=GAP_CYCLES-1.
  - GAP_CYCLES==0 -> IDLE, with done=1 in the TERM cycle.
- GAP: x_out=0. Counter decrements; when counter==0 -> IDLE, with done=1 in this last GAP cycle.
- Turnaround: req_ready is high again in cycle k+len+2+GAP_CYCLES (len>=1). Minimum request-to-request period is len+2+GAP_CYCLES cycles.
- len==0 transaction: TERM then GAP only; x_out never rises, expect_y stays 0.
- req_valid while busy is ignored and not queued; req_len changes while busy have no effect.
- Counter width is max(LEN_W, clog2(GAP_CYCLES+1)). Decrement never wraps: the transition is taken at 0.
- Detector contract: with the detector reset in S0 and x_out as its x_in, detector y_out==expect_y in every cycle after reset release.

Decomposition:
- Shared package (ones_run_pkg):
  - state localparams IDLE=2'b00, RUN=2'b01, TERM=2'b10, GAP=2'b11
  - default LEN_W
  - helper function for counter width
- One sub-module: ones_run_counter, a loadable down-counter with load, dec, and is_zero outputs. It is shared by the RUN and GAP phases.
- The top holds the FSM, request latch, and output decode.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=1 -> x_out=0, busy=0, req_ready=1, no acceptance. First acceptance occurs on the first edge after release.
- Single run: GAP_CYCLES=1, req_len=3 accepted at edge 0 -> x_out=1 in cycles 1-3, x_out=0 with expect_y=1 in cycle 4, done=1 in cycle 5, req_ready=1 in cycle 6. Detector y_out=1 only in cycle 4.
- Zero length: req_len=0 -> x_out stays 0 throughout, expect_y=0, done pulse 2 cycles after acceptance, ready again on cycle 3.
- Max length and back-to-back: req_len=15, then req_len=1 held valid -> 15 ones, term, gap, then exactly 1 one. The second request is accepted only when req_ready=1; no requests are lost or duplicated.
- Busy ignore: while in RUN, toggle req_valid and change req_len -> emitted run length unchanged, no extra transaction.
- Reset mid-run: assert reset during cycle 2 of a len=5 run -> next cycle x_out=0, state IDLE, expect_y never asserted. Repeat with GAP_CYCLES=0 parameterisation: done coincides with TERM.
